// File: rtl/kmeans_assign_ctrl.sv
// Nearest-centroid search sequencer: walks centroids 0..K-1, tracks running minimum distance and its index.
// Optional abort input enabled by defining KMEANS_ASSIGN_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for start, results from the last search held
// RUN   | requesting distances, one per accepted transfer
// DONE  | single-cycle completion pulse, start here chains the next search
module kmeans_assign_ctrl #(
    parameter int DW   = 64,
    parameter int K    = 8,
    parameter int IDXW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
`ifdef KMEANS_ASSIGN_ABORT_EN
    input  logic            abort,
`endif
    output logic            busy,
    output logic [IDXW-1:0] cent_idx,
    input  logic            dist_valid,
    output logic            dist_ready,
    input  logic [DW-1:0]   dist_data,
    output logic [DW-1:0]   best_dist,
    output logic [IDXW-1:0] best_idx,
    output logic            done
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(K - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    logic   abort_req;
    logic   xfer;

`ifdef KMEANS_ASSIGN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // dist_ready is high exactly in RUN, so this is the accepted-transfer strobe
    assign xfer = dist_valid & dist_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            dist_ready <= 1'b0;
            done       <= 1'b0;
            cent_idx   <= '0;
            best_dist  <= '1;
            best_idx   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        dist_ready <= 1'b1;
                        cent_idx   <= '0;
                        best_dist  <= '1;
                        best_idx   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (abort_req) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        dist_ready <= 1'b0;
                        cent_idx   <= '0;
                        best_dist  <= '1;
                        best_idx   <= '0;
                    end else if (xfer) begin
                        // strict compare so ties keep the lower centroid index
                        if (dist_data < best_dist) begin
                            best_dist <= dist_data;
                            best_idx  <= cent_idx;
                        end
                        if (cent_idx == LAST_IDX) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            dist_ready <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            cent_idx <= cent_idx + IDXW'(1);
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    dist_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kmeans_assign_ctrl.sv
// Self-checking bench for kmeans_assign_ctrl; reference result is min value then first index holding it.
module tb_kmeans_assign_ctrl;

    localparam int DW   = 64;
    localparam int K    = 8;
    localparam int IDXW = 3;
    localparam logic [DW-1:0] ONES = '1;

    typedef logic [DW-1:0] dvec_t [K];

    logic            clk;
    logic            reset;
    logic            start;
    logic            abort;
    logic            busy;
    logic [IDXW-1:0] cent_idx;
    logic            dist_valid;
    logic            dist_ready;
    logic [DW-1:0]   dist_data;
    logic [DW-1:0]   best_dist;
    logic [IDXW-1:0] best_idx;
    logic            done;

    int n_tests = 0;
    int n_fail  = 0;

    kmeans_assign_ctrl #(.DW(DW), .K(K), .IDXW(IDXW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
`ifdef KMEANS_ASSIGN_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .cent_idx   (cent_idx),
        .dist_valid (dist_valid),
        .dist_ready (dist_ready),
        .dist_data  (dist_data),
        .best_dist  (best_dist),
        .best_idx   (best_idx),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected result over the first n distances: smallest value, lowest index holding it
    function automatic void ref_best(input dvec_t d, input int n,
                                     output logic [DW-1:0] v, output logic [IDXW-1:0] ix);
        logic [DW-1:0] m;
        v  = ONES;
        ix = '0;
        if (n > 0) begin
            m = d[0];
            for (int j = 1; j < n; j++) if (d[j] < m) m = d[j];
            for (int j = n - 1; j >= 0; j--) if (d[j] == m) ix = IDXW'(j);
            v = m;
        end
    endfunction

    task automatic begin_search(input string tag);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || dist_ready !== 1'b1 || cent_idx !== '0 || done !== 1'b0)
            begin n_fail++; $display("FAIL %s start: busy=%b ready=%b idx=%0d done=%b, required 1 1 0 0",
                                     tag, busy, dist_ready, cent_idx, done); end
        n_tests++;
        if (best_dist !== ONES || best_idx !== '0)
            begin n_fail++; $display("FAIL %s start_reload: best_dist=%h best_idx=%0d, required all-ones 0",
                                     tag, best_dist, best_idx); end
    endtask

    task automatic feed(input dvec_t d, input int stall_min, input int stall_max,
                        input int mid_start_at, input string tag);
        logic [DW-1:0]   ev;
        logic [IDXW-1:0] ei;
        int              ns;
        for (int i = 0; i < K; i++) begin
            ns = int'($urandom_range(stall_max, stall_min));
            for (int s = 0; s < ns; s++) begin
                dist_valid = 1'b0;
                dist_data  = {$urandom, $urandom};
                @(posedge clk); #1;
                n_tests++;
                if (busy !== 1'b1 || cent_idx !== IDXW'(i) || done !== 1'b0)
                    begin n_fail++; $display("FAIL %s stall[%0d]: busy=%b idx=%0d done=%b, required 1 %0d 0",
                                             tag, i, busy, cent_idx, done, i); end
            end
            ref_best(d, i, ev, ei);
            n_tests++;
            if (best_dist !== ev || best_idx !== ei)
                begin n_fail++; $display("FAIL %s running[%0d]: best_dist=%0d best_idx=%0d, required %0d %0d",
                                         tag, i, best_dist, best_idx, ev, ei); end
            n_tests++;
            if (cent_idx !== IDXW'(i) || busy !== 1'b1 || dist_ready !== 1'b1 || done !== 1'b0)
                begin n_fail++; $display("FAIL %s step[%0d]: idx=%0d busy=%b ready=%b done=%b, required %0d 1 1 0",
                                         tag, i, cent_idx, busy, dist_ready, done, i); end
            dist_valid = 1'b1;
            dist_data  = d[i];
            if (i == mid_start_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        dist_valid = 1'b0;
        ref_best(d, K, ev, ei);
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || dist_ready !== 1'b0)
            begin n_fail++; $display("FAIL %s done_flags: done=%b busy=%b ready=%b, required 1 0 0",
                                     tag, done, busy, dist_ready); end
        n_tests++;
        if (best_dist !== ev || best_idx !== ei)
            begin n_fail++; $display("FAIL %s result: best_dist=%0d best_idx=%0d, required %0d %0d",
                                     tag, best_dist, best_idx, ev, ei); end
    endtask

    task automatic finish_idle(input dvec_t d, input string tag);
        logic [DW-1:0]   ev;
        logic [IDXW-1:0] ei;
        ref_best(d, K, ev, ei);
        start = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || best_dist !== ev || best_idx !== ei)
            begin n_fail++; $display("FAIL %s after_done: done=%b busy=%b best=%0d idx=%0d, required 0 0 %0d %0d",
                                     tag, done, busy, best_dist, best_idx, ev, ei); end
    endtask

    task automatic test_reset();
        n_tests++;
        if (busy !== 1'b0 || dist_ready !== 1'b0 || done !== 1'b0 || cent_idx !== '0 ||
            best_dist !== ONES || best_idx !== '0)
            begin n_fail++; $display("FAIL reset_values: busy=%b ready=%b done=%b idx=%0d best=%h bidx=%0d",
                                     busy, dist_ready, done, cent_idx, best_dist, best_idx); end
    endtask

    task automatic test_directed();
        dvec_t d;
        d = '{64'd50, 64'd40, 64'd60, 64'd40, 64'd10, 64'd90, 64'd10, 64'd70};
        begin_search("directed");
        feed(d, 0, 0, -1, "directed");
        n_tests++;
        if (best_dist !== 64'd10 || best_idx !== 3'd4)
            begin n_fail++; $display("FAIL directed_const: best_dist=%0d best_idx=%0d, required 10 4",
                                     best_dist, best_idx); end
        finish_idle(d, "directed");
    endtask

    task automatic test_all_ones();
        dvec_t d;
        for (int i = 0; i < K; i++) d[i] = ONES;
        begin_search("all_ones");
        feed(d, 0, 1, -1, "all_ones");
        finish_idle(d, "all_ones");
    endtask

    task automatic test_stall();
        dvec_t d;
        d[0] = 64'd30;
        d[1] = 64'd20;
        for (int i = 2; i < K; i++) d[i] = 64'($urandom_range(15, 200));
        begin_search("stall");
        feed(d, 5, 5, -1, "stall");
        finish_idle(d, "stall");
    endtask

    task automatic test_random();
        dvec_t d;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < K; i++)
                d[i] = (r % 2 == 0) ? 64'($urandom_range(0, 7)) : {$urandom, $urandom};
            begin_search("random");
            feed(d, 0, 3, -1, "random");
            finish_idle(d, "random");
        end
    endtask

    task automatic test_back_to_back();
        dvec_t d1;
        dvec_t d2;
        for (int i = 0; i < K; i++) begin
            d1[i] = 64'($urandom_range(0, 20));
            d2[i] = 64'($urandom_range(100, 120));
        end
        begin_search("b2b_first");
        feed(d1, 0, 0, -1, "b2b_first");
        // still in the DONE cycle: start here chains straight into the next search
        begin_search("b2b_second");
        feed(d2, 0, 2, 3, "b2b_second");
        finish_idle(d2, "b2b_second");
    endtask

    task automatic test_ignore_idle();
        dvec_t d;
        for (int i = 0; i < K; i++) d[i] = 64'($urandom_range(50, 60));
        begin_search("idle_ign");
        feed(d, 0, 0, -1, "idle_ign");
        finish_idle(d, "idle_ign");
        for (int c = 0; c < 3; c++) begin
            dist_valid = 1'b1;
            dist_data  = '0;
            @(posedge clk); #1;
        end
        dist_valid = 1'b0;
        finish_idle(d, "idle_ign");
    endtask

    task automatic test_async_reset();
        dvec_t d;
        for (int i = 0; i < K; i++) d[i] = 64'($urandom_range(0, 1000));
        begin_search("areset");
        for (int i = 0; i < 3; i++) begin
            dist_valid = 1'b1;
            dist_data  = 64'd1;
            @(posedge clk); #1;
        end
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || dist_ready !== 1'b0 || done !== 1'b0 || cent_idx !== '0 ||
            best_dist !== ONES || best_idx !== '0)
            begin n_fail++; $display("FAIL areset_immediate: busy=%b ready=%b done=%b idx=%0d best=%h bidx=%0d",
                                     busy, dist_ready, done, cent_idx, best_dist, best_idx); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (done !== 1'b0 || busy !== 1'b0)
                begin n_fail++; $display("FAIL areset_no_done: done=%b busy=%b, required 0 0", done, busy); end
        end
        dist_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        begin_search("areset_fresh");
        feed(d, 0, 1, -1, "areset_fresh");
        finish_idle(d, "areset_fresh");
    endtask

`ifdef KMEANS_ASSIGN_ABORT_EN
    task automatic test_abort();
        begin_search("abort");
        for (int i = 0; i < 4; i++) begin
            dist_valid = 1'b1;
            dist_data  = 64'(100 + i);
            @(posedge clk); #1;
        end
        dist_valid = 1'b1;
        dist_data  = 64'd1;
        abort      = 1'b1;
        @(posedge clk); #1;
        abort      = 1'b0;
        dist_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || dist_ready !== 1'b0 || done !== 1'b0 || cent_idx !== '0 ||
            best_dist !== ONES || best_idx !== '0)
            begin n_fail++; $display("FAIL abort_state: busy=%b ready=%b done=%b idx=%0d best=%0d bidx=%0d",
                                     busy, dist_ready, done, cent_idx, best_dist, best_idx); end
        @(posedge clk); #1;
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL abort_no_done: done=%b busy=%b", done, busy); end
        abort = 1'b1;
        begin_search("abort_idle_ign");
        abort = 1'b0;
    endtask
`endif

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        dist_valid = 1'b0;
        dist_data  = '0;
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_all_ones();
        test_stall();
        test_random();
        test_back_to_back();
        test_ignore_idle();
        test_async_reset();
`ifdef KMEANS_ASSIGN_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/kmeans_assign_ctrl.md
# kmeans_assign_ctrl

Sequences the nearest-centroid search for one K-means sample. Steps a centroid index through 0..K-1, accepts one distance per centroid over a valid/ready handshake, and keeps a running-minimum distance register plus the index of the winning centroid. Sits between the distance datapath and the cluster-assignment / accumulation stage. The minimum register starts each search at all-ones, which is the maximum distance.

## Interface
- DW, 64, distance width in bits
- K, 8, number of centroids (K ≥ 2)
- IDXW, 3, centroid index width; must satisfy 2^IDXW ≥ K
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- start  in  1  begin a search; accepted only when busy=0
- busy  out  1  search in progress
- cent_idx  out  IDXW  centroid whose distance is currently requested
- dist_valid  in  1  dist_data valid
- dist_ready  out  1  controller accepts dist_data
- dist_data  in  DW  distance for centroid cent_idx
- best_dist  out  DW  running / final minimum distance
- best_idx  out  IDXW  centroid index of best_dist
- done  out  1  one-cycle pulse: search complete, results valid

## Operation
- FSM states and transitions:
  - IDLE: on start, go to RUN.
  - RUN: go to DONE after the K-th accepted distance.
  - DONE: exactly one cycle. On start, go to RUN; otherwise go to IDLE.
- Start acceptance:
  - Accepted when start=1 in IDLE or DONE.
  - Ignored in RUN.
- On accepted start:
  - best_dist ← all-ones.
  - best_idx ← 0.
  - cent_idx ← 0.
- RUN state:
  - dist_ready=1 and busy=1.
  - A transfer occurs when dist_valid & dist_ready.
- On each transfer:
  - If dist_data < best_dist (unsigned, strict), then best_dist ← dist_data and best_idx ← cent_idx.
  - If cent_idx == K-1, go to DONE and hold cent_idx. Otherwise cent_idx ← cent_idx+1.
- Ties keep the lower index, because the comparison is strict.
- If every distance equals all-ones, the result is best_dist=all-ones and best_idx=0.
- dist_valid=0 in RUN stalls the search indefinitely with no state change.
- DONE state:
  - done=1, busy=0, dist_ready=0.
  - best_dist and best_idx hold until the next accepted start.
- Outside RUN, dist_valid is ignored.
- Reset (asynchronous, any state): the block returns to its reset values, so a search in progress is abandoned with no done pulse.
- Reset values of all outputs: busy=0, dist_ready=0, done=0, cent_idx=0, best_dist=all-ones, best_idx=0; state IDLE.

## Timing
- Start accepted at edge t: at t+1, busy=1, dist_ready=1, cent_idx=0.
- One distance can be accepted per cycle. Zero-stall search: K cycles in RUN.
- K-th transfer at edge u: at u+1, done=1 with final best_dist/best_idx; busy=0.
- Start asserted during the DONE cycle: RUN at u+2, giving back-to-back searches with one bubble cycle.
- best_dist/best_idx update on the edge of the transfer, so they are visible the next cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- KMEANS_ASSIGN_ABORT_EN defined:
  - Adds input port `abort` (1 bit).
  - abort=1 in RUN: at the next edge, go to IDLE with best_dist=all-ones, best_idx=0, cent_idx=0, and no done pulse.
  - abort has priority over a same-cycle transfer.
  - abort is ignored in IDLE/DONE.
  - If start and abort are both high in DONE, start wins.
- KMEANS_ASSIGN_ABORT_EN undefined:
  - No abort port.
  - A search ends only by completion or reset.

## Test plan
- K=8, start, distances 50,40,60,40,10,90,10,70 with no stalls → done at cycle 9 after start, best_dist=10, best_idx=4.
- All 8 distances = 64'hFFFF_FFFF_FFFF_FFFF → best_dist=all-ones, best_idx=0, done pulse exactly one cycle.
- Stall test: distances 30,20,… with dist_valid low for 5 cycles before each → cent_idx advances only on transfers, result identical to the no-stall run, busy stays high throughout.
- Start held high in DONE → second search begins with best_dist reloaded to all-ones; a start pulse mid-RUN → ignored, cent_idx unaffected.
- Reset low asynchronously after 3 transfers → outputs immediately at reset values, no done pulse; next start yields a fresh correct result.
- With KMEANS_ASSIGN_ABORT_EN: abort at the 5th transfer cycle → IDLE next cycle, best_dist=all-ones, no done; the 5th distance is not captured.
